// File: rtl/prog_run_ctrl.sv
// Run sequencer for the fetch unit: start/hold/run/done control, per-program start address, cycle count.
// Optional watchdog enabled by defining PRC_TIMEOUT_EN (adds TIMEOUT parameter and drives TimedOut).
module prog_run_ctrl #(
  parameter int T       = 10,
  parameter int NPROG   = 3,
  parameter int START0  = 0,
  parameter int START1  = 128,
  parameter int START2  = 256,
  parameter int START3  = 384,
  parameter int CYC_W   = 16
`ifdef PRC_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 4095
`endif
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req,
  input  logic             HaltInst,
  output logic             FetchStart,
  output logic [T-1:0]     StartAddr,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       ProgIdx,
  output logic [CYC_W-1:0] CycleCount,
  output logic             TimedOut
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  localparam int START_P [4] = '{START0, START1, START2, START3};

  state_t           r_state;
  logic             r_fetch_start;
  logic             r_busy;
  logic             r_done;
  logic [1:0]       r_prog_idx;
  logic [CYC_W-1:0] r_cycle_count;

  logic [T-1:0]     w_start_tab [4];
  logic [1:0]       w_idx_next;
  logic [CYC_W-1:0] w_count_inc;
  logic             w_timeout;
  logic             w_run_exit;

  for (genvar gi = 0; gi < 4; gi++) begin : g_start_tab
    assign w_start_tab[gi] = T'(START_P[gi]);
  end

  assign w_idx_next  = (r_prog_idx == 2'(NPROG - 1)) ? 2'd0 : r_prog_idx + 2'd1;
  // Saturate rather than wrap so a runaway program never reports a small count.
  assign w_count_inc = (&r_cycle_count) ? r_cycle_count : r_cycle_count + CYC_W'(1);

`ifdef PRC_TIMEOUT_EN
  logic r_timed_out;

  assign w_timeout = (w_count_inc == CYC_W'(TIMEOUT));

  // Halt on the same cycle as the limit is a normal finish, not a timeout.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_timed_out <= 1'b0;
    end else if (r_state == S_HOLD && !Req) begin
      r_timed_out <= 1'b0;
    end else if (r_state == S_RUN && !HaltInst && w_timeout) begin
      r_timed_out <= 1'b1;
    end
  end

  assign TimedOut = r_timed_out;
`else
  assign w_timeout = 1'b0;
  assign TimedOut  = 1'b0;
`endif

  assign w_run_exit = HaltInst || w_timeout;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_prog_idx    <= 2'd0;
      r_cycle_count <= '0;
      r_fetch_start <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Req) begin
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!Req) begin
            r_state       <= S_RUN;
            r_cycle_count <= '0;
            r_fetch_start <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        S_RUN: begin
          r_cycle_count <= w_count_inc;
          if (w_run_exit) begin
            r_state       <= S_DONE;
            r_fetch_start <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
          end
        end
        S_DONE: begin
          // Index advances only when the bench asks for the next program.
          if (Req) begin
            r_state    <= S_HOLD;
            r_done     <= 1'b0;
            r_prog_idx <= w_idx_next;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign FetchStart = r_fetch_start;
  assign StartAddr  = w_start_tab[r_prog_idx];
  assign Busy       = r_busy;
  assign Done       = r_done;
  assign ProgIdx    = r_prog_idx;
  assign CycleCount = r_cycle_count;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Scoreboard bench for prog_run_ctrl: driver pushes expected run results, monitor checks on Done rise.
module tb_prog_run_ctrl;

  localparam int NPROG = 3;
`ifdef PRC_TIMEOUT_EN
  localparam int TB_TMO = 20;
`else
  localparam int TB_TMO = 1 << 30;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req;
  logic        HaltInst;
  logic        FetchStart;
  logic [9:0]  StartAddr;
  logic        Busy;
  logic        Done;
  logic [1:0]  ProgIdx;
  logic [15:0] CycleCount;
  logic        TimedOut;

  always #5 Clk = ~Clk;

  prog_run_ctrl #(
    .NPROG(NPROG)
`ifdef PRC_TIMEOUT_EN
    ,
    .TIMEOUT(TB_TMO)
`endif
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Req(Req),
    .HaltInst(HaltInst),
    .FetchStart(FetchStart),
    .StartAddr(StartAddr),
    .Busy(Busy),
    .Done(Done),
    .ProgIdx(ProgIdx),
    .CycleCount(CycleCount),
    .TimedOut(TimedOut)
  );

  typedef struct {
    int idx;
    int cnt;
    int to;
  } exp_t;

  exp_t exp_q[$];
  int   start_tab[4] = '{0, 128, 256, 384};
  int   n_vec = 0;
  int   n_err = 0;
  int   model_idx = 0;
  bit   in_done = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Req = 1'b0;
    HaltInst = 1'b0;
    step();
    Reset = 1'b0;
    chk("rst_idx", int'(ProgIdx), 0);
    chk("rst_cnt", int'(CycleCount), 0);
    chk("rst_fetch", int'(FetchStart), 1);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_to", int'(TimedOut), 0);
    chk("rst_addr", int'(StartAddr), 0);
    model_idx = 0;
    in_done = 1'b0;
  endtask

  // Request, hold for 'hold' edges, release; returns with the DUT in its first RUN cycle.
  task automatic start_run(input int hold);
    if (in_done) model_idx = (model_idx + 1) % NPROG;
    in_done = 1'b0;
    Req = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_fetch", int'(FetchStart), 1);
      chk("hold_addr", int'(StartAddr), start_tab[model_idx]);
      chk("hold_idx", int'(ProgIdx), model_idx);
      chk("hold_busy", int'(Busy), 0);
      chk("hold_done", int'(Done), 0);
      HaltInst = 1'($urandom_range(0, 1));
    end
    Req = 1'b0;
    HaltInst = 1'b0;
    step();
    chk("run_busy", int'(Busy), 1);
    chk("run_fetch", int'(FetchStart), 0);
    chk("run_cnt0", int'(CycleCount), 0);
    chk("run_to0", int'(TimedOut), 0);
  endtask

  // Halt arrives on the len-th RUN cycle unless the watchdog ends the run first.
  task automatic do_run(input int hold, input int len, input int dwell);
    exp_t e;
    int   cap;
    start_run(hold);
    cap = (len <= TB_TMO) ? len : TB_TMO;
    e.idx = model_idx;
    e.cnt = cap;
    e.to  = (len > TB_TMO) ? 1 : 0;
    exp_q.push_back(e);
    for (int k = 1; k <= cap; k++) begin
      HaltInst = (k == len);
      Req = ($urandom_range(0, 3) == 0);
      step();
      if (k < cap) begin
        chk("run_busy_k", int'(Busy), 1);
        chk("run_cnt_k", int'(CycleCount), k);
        chk("run_done_k", int'(Done), 0);
      end
    end
    Req = 1'b0;
    HaltInst = 1'b0;
    chk("done_now", int'(Done), 1);
    for (int i = 0; i < dwell; i++) begin
      HaltInst = 1'($urandom_range(0, 1));
      step();
      chk("done_hold", int'(Done), 1);
      chk("done_idx_stable", int'(ProgIdx), model_idx);
      chk("done_cnt_frozen", int'(CycleCount), cap);
    end
    HaltInst = 1'b0;
    in_done = 1'b1;
  endtask

  task automatic abort_run(input int hold, input int n);
    start_run(hold);
    for (int k = 1; k <= n; k++) begin
      step();
    end
    chk("abort_pre_idx", int'(ProgIdx), model_idx);
    do_reset();
  endtask

  // Monitor: one scoreboard entry per Done rising edge.
  initial begin
    bit   done_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Done && !done_prev) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_done: Done=1 with no run outstanding, expected 0");
        end else begin
          e = exp_q.pop_front();
          $display("run: idx=%0d cycles=%0d timedout=%0d (exp %0d/%0d/%0d)",
                   ProgIdx, CycleCount, TimedOut, e.idx, e.cnt, e.to);
          chk("sb_idx", int'(ProgIdx), e.idx);
          chk("sb_cnt", int'(CycleCount), e.cnt);
          chk("sb_to", int'(TimedOut), e.to);
          chk("sb_addr", int'(StartAddr), start_tab[e.idx]);
          chk("sb_busy", int'(Busy), 0);
          chk("sb_fetch", int'(FetchStart), 1);
        end
      end
      done_prev = Done;
    end
  end

  initial begin
    Reset = 1'b1;
    Req = 1'b0;
    HaltInst = 1'b0;
    step();
    do_reset();

    // Halt in IDLE must be ignored
    HaltInst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_busy", int'(Busy), 0);
      chk("idle_done", int'(Done), 0);
      chk("idle_fetch", int'(FetchStart), 1);
    end
    HaltInst = 1'b0;

    do_run(5, 38, 2);
    do_run(2, 7, 1);
    do_run(3, 1, 0);
    do_run(1, 12, 3);

    do_reset();
    do_run(2, 4, 1);
    abort_run(2, 9);

    for (int r = 0; r < 12; r++) begin
      do_run($urandom_range(1, 6), $urandom_range(1, 60), $urandom_range(0, 3));
    end

`ifdef PRC_TIMEOUT_EN
    do_run(2, 30, 2);
    do_run(2, 5, 1);
    do_run(1, TB_TMO, 1);
`endif

    repeat (3) step();
    chk("queue_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
